// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode slice.
package pipe_pkg;

   typedef logic [31:0] word_t;

   localparam word_t RESET_PC_DEF = 32'h0000_3000;

   // Comparator condition codes driven by the decoder
   localparam logic [2:0] BCP_EQ  = 3'b000;
   localparam logic [2:0] BCP_NE  = 3'b001;
   localparam logic [2:0] BCP_LEZ = 3'b010;
   localparam logic [2:0] BCP_GTZ = 3'b011;
   localparam logic [2:0] BCP_LTZ = 3'b100;
   localparam logic [2:0] BCP_GEZ = 3'b101;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (en && inc && count != '1)
         count <= count + W'(1);
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC owner: next-PC select, deferred redirect
// while imem stalls, and branch statistics.
module branch_pc_unit
   import pipe_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEF,
   parameter int    CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             imem_ready,
   input  logic             id_valid,
   input  logic [31:0]      id_pc,
   input  logic             is_branch,
   input  logic             zero,
   input  logic [15:0]      imm16,
   input  logic             is_jump,
   input  logic [25:0]      instr_index,
   input  logic             is_jr,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             imem_req,
   output logic             redirect,
   output logic [CNT_W-1:0] br_total,
   output logic [CNT_W-1:0] br_taken
);

   logic  req_q;
   logic  pend_valid;
   word_t pend_target;
   logic  id_fire;
   logic  ev;
   logic  adv;
   word_t id_pc_plus4;
   word_t br_off;
   word_t target;

   assign pc_plus4    = pc + 32'd4;
   assign id_pc_plus4 = id_pc + 32'd4;
   assign br_off      = {{14{imm16[15]}}, imm16, 2'b00};

   assign imem_req = req_q & reset_n;
   assign id_fire  = id_valid && !stall;
   assign ev       = id_fire &&
                     (is_jr || is_jump ||
                      (is_branch && zero));
   assign adv      = imem_ready && !stall && req_q;

   // jr outranks jump, jump outranks branch
   always_comb begin
      target = id_pc_plus4 + br_off;
      if (is_jr)
         target = jr_target;
      else if (is_jump)
         target = {id_pc_plus4[31:28],
                   instr_index, 2'b00};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         redirect    <= 1'b0;
         req_q       <= 1'b0;
      end else begin
         req_q    <= 1'b1;
         redirect <= 1'b0;
         if (adv && ev) begin
            pc         <= target;
            pend_valid <= 1'b0;
            redirect   <= 1'b1;
         end else if (adv && pend_valid) begin
            pc         <= pend_target;
            pend_valid <= 1'b0;
            redirect   <= 1'b1;
         end else if (adv) begin
            pc <= pc_plus4;
         end else if (ev) begin
            // latest event wins over any older pending one
            pend_valid  <= 1'b1;
            pend_target <= target;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_total (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (id_fire && is_branch),
      .inc     (1'b1),
      .count   (br_total)
   );

   sat_counter #(.W(CNT_W)) u_taken (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (id_fire && is_branch),
      .inc     (zero),
      .count   (br_taken)
   );

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed plan
// followed by randomized traffic against a reference model.
module tb_branch_pc_unit;

   localparam int          CW   = 6;
   localparam int          MAXC = (1 << CW) - 1;
   localparam logic [31:0] RPC  = 32'h0000_3000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          stall = 1'b0;
   logic          imem_ready = 1'b0;
   logic          id_valid = 1'b0;
   logic [31:0]   id_pc = '0;
   logic          is_branch = 1'b0;
   logic          zero = 1'b0;
   logic [15:0]   imm16 = '0;
   logic          is_jump = 1'b0;
   logic [25:0]   instr_index = '0;
   logic          is_jr = 1'b0;
   logic [31:0]   jr_target = '0;
   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic          imem_req;
   logic          redirect;
   logic [CW-1:0] br_total;
   logic [CW-1:0] br_taken;

   typedef struct {
      logic [31:0] pc;
      logic        redir;
      int          tot;
      int          tk;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;

   logic [31:0] m_pc;
   logic        m_req;
   logic [31:0] m_pend[$];
   int          m_tot;
   int          m_tk;

   always #5 clk = ~clk;

   branch_pc_unit #(
      .RESET_PC (RPC),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .stall       (stall),
      .imem_ready  (imem_ready),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .is_branch   (is_branch),
      .zero        (zero),
      .imm16       (imm16),
      .is_jump     (is_jump),
      .instr_index (instr_index),
      .is_jr       (is_jr),
      .jr_target   (jr_target),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .imem_req    (imem_req),
      .redirect    (redirect),
      .br_total    (br_total),
      .br_taken    (br_taken)
   );

   function automatic void check(string name,
                                 logic [31:0] act,
                                 logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h",
                  name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_pc  = RPC;
      m_req = 1'b0;
      m_pend.delete();
      m_tot = 0;
      m_tk  = 0;
   endfunction

   function automatic void check_reset_vals();
      check("rst_pc", pc, RPC);
      check("rst_redirect", 32'(redirect), 0);
      check("rst_imem_req", 32'(imem_req), 0);
      check("rst_br_total", 32'(br_total), 0);
      check("rst_br_taken", 32'(br_taken), 0);
   endfunction

   // monitor: compare after every edge that has an expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("pc_plus4", pc_plus4, e.pc + 32'd4);
            check("redirect", 32'(redirect),
                  32'(e.redir));
            check("imem_req", 32'(imem_req), 1);
            check("br_total", 32'(br_total),
                  32'(e.tot));
            check("br_taken", 32'(br_taken),
                  32'(e.tk));
         end
      end
   end

   task automatic step(input logic st, rdy, v,
                       input logic br, z, j, jr,
                       input logic [31:0] ipc, jt,
                       input logic [15:0] im,
                       input logic [25:0] idx);
      logic        fire;
      logic        ev;
      logic        adv;
      logic        redir;
      logic [31:0] tgt;
      exp_t        e;
      @(negedge clk);
      reset_n     = 1'b1;
      stall       = st;
      imem_ready  = rdy;
      id_valid    = v;
      is_branch   = br;
      zero        = z;
      is_jump     = j;
      is_jr       = jr;
      id_pc       = ipc;
      jr_target   = jt;
      imm16       = im;
      instr_index = idx;
      fire = v && !st;
      ev   = fire && (jr || j || (br && z));
      if (jr)
         tgt = jt;
      else if (j)
         tgt = ((ipc + 32'd4) & 32'hF000_0000)
               | (32'(idx) * 4);
      else
         tgt = ipc + 32'd4
               + 32'(4 * int'($signed(im)));
      adv   = rdy && !st && m_req;
      redir = 1'b0;
      if (adv) begin
         redir = 1'b1;
         if (ev) begin
            m_pc = tgt;
            m_pend.delete();
         end else if (m_pend.size() > 0) begin
            m_pc = m_pend.pop_front();
         end else begin
            m_pc  = m_pc + 32'd4;
            redir = 1'b0;
         end
      end else if (ev) begin
         m_pend.delete();
         m_pend.push_back(tgt);
      end
      if (fire && br) begin
         if (m_tot < MAXC) m_tot++;
         if (z && m_tk < MAXC) m_tk++;
      end
      m_req   = 1'b1;
      e.pc    = m_pc;
      e.redir = redir;
      e.tot   = m_tot;
      e.tk    = m_tk;
      sb.push_back(e);
   endtask

   task automatic idle();
      step(0, 1, 0, 0, 0, 0, 0, '0, '0, '0, '0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();
   endtask

   initial begin
      model_reset();
      #12;
      check_reset_vals();

      idle(); idle(); idle();
      settle();
      check("run_pc", pc, 32'h3008);

      step(0, 1, 1, 1, 1, 0, 0,
           32'h3010, '0, 16'h0004, '0);
      settle();
      check("beq_pc", pc, 32'h3024);
      check("beq_redir", 32'(redirect), 1);
      idle();

      step(0, 1, 1, 1, 0, 0, 0,
           32'h3020, '0, 16'hFFFF, '0);
      step(0, 1, 1, 1, 1, 0, 0,
           32'h3020, '0, 16'hFFFF, '0);
      settle();
      check("bne_back_pc", pc, 32'h3020);
      check("bne_total", 32'(br_total), 3);
      check("bne_taken", 32'(br_taken), 2);

      step(0, 0, 1, 1, 1, 0, 0,
           32'h3100, '0, 16'h0008, '0);
      step(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
      step(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
      settle();
      check("pend_hold_pc", pc, 32'h3020);
      idle();
      settle();
      check("pend_apply_pc", pc, 32'h3124);
      check("pend_redir", 32'(redirect), 1);

      step(1, 1, 1, 1, 1, 0, 0,
           32'h3200, '0, 16'h0010, '0);
      settle();
      check("stall_pc", pc, 32'h3124);
      check("stall_total", 32'(br_total), 4);

      step(0, 1, 1, 1, 1, 1, 1,
           32'h3300, 32'h4000, 16'h0020, 26'h123);
      settle();
      check("prio_pc", pc, 32'h4000);

      step(0, 1, 1, 0, 0, 0, 1,
           32'h4000, 32'hFFFF_FFFC, '0, '0);
      idle();
      settle();
      check("wrap_pc", pc, 32'h0);

      for (int i = 0; i < 70; i++)
         step(0, 1, 1, 1, 1, 0, 0,
              $urandom, '0, 16'($urandom), '0);
      settle();
      check("sat_total", 32'(br_total), MAXC);
      check("sat_taken", 32'(br_taken), MAXC);
      idle();

      step(0, 0, 1, 0, 0, 1, 0,
           32'h1000_0000, '0, '0, 26'h3);
      do_reset();
      idle(); idle();

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(499) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(7) == 0,
                 $urandom_range(3) != 0,
                 $urandom_range(3) != 0,
                 $urandom_range(2) == 0,
                 1'($urandom),
                 $urandom_range(7) == 0,
                 $urandom_range(9) == 0,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom & 32'hFFFF_FFFC,
                 16'($urandom),
                 26'($urandom));
         end
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(posedge clk);
      #2;
      check("drain_left", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
